dot_product_unit: RTL and testbench

Sequential dot-product stage downstream of the SPI-loaded weight and data registers. On a start pulse it snapshots the 32-bit weight vector (16 × 2-bit signed weights) and the 128-bit data vector (16 × 8-bit unsigned samples). It then accumulates one product per cycle over 16 cycles and presents a 14-bit signed result with a one-cycle done pulse. The top level drives its `start`/`abort` from decoded `ui_in` control bits and routes `result` and the flags to `uo_out`/`uio_out`.

---
 rtl/dot_product_unit.sv | 139 +++++++++++++
 tb/tb_dot_product_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_unit.sv
// dot_product_unit
//
// Sequential 16-element dot product. A start pulse snapshots the weight
// vector (16 x 2-bit signed) and the data vector (16 x 8-bit unsigned). One
// product is accumulated per cycle. The signed result is published with a
// one-cycle done pulse.
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   begin a computation (ignored while busy)
//   abort    in   cancel an in-progress computation (beats start in IDLE)
//   weights  in   element i weight = weights[2i+1:2i], signed -2..+1
//   data     in   element i sample = data[8i+7:8i], unsigned 0..255
//   busy     out  computation in progress
//   done     out  one-cycle pulse when result updates
//   result   out  signed dot product, held until the next completion
//
// Optional build macro: DOT_RELU_EN. When it is defined, a negative final sum
// loads 0 into result. The accumulator itself is never clamped.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; result holds the last completed value
// RUN   | accumulating element idx; finishes after idx = N_ELEM-1

module dot_product_unit #(
    parameter int N_ELEM = 16,
    parameter int ACC_W  = 14
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [2*N_ELEM-1:0]    weights,
    input  logic [8*N_ELEM-1:0]    data,
    output logic                   busy,
    output logic                   done,
    output logic [ACC_W-1:0]       result
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [3:0] IDX_LAST = 4'(N_ELEM - 1);

    state_t                     state_q;
    logic [3:0]                 idx_q;
    logic signed [ACC_W-1:0]    acc_q;
    logic [2*N_ELEM-1:0]        w_snap_q;
    logic [8*N_ELEM-1:0]        d_snap_q;
    logic                       busy_q;
    logic                       done_q;
    logic [ACC_W-1:0]           result_q;

    logic [1:0]                 w_sel;
    logic [7:0]                 d_sel;
    logic signed [ACC_W-1:0]    w_ext;
    logic signed [ACC_W-1:0]    d_ext;
    logic signed [ACC_W-1:0]    term;
    logic signed [ACC_W-1:0]    acc_d;
    logic [ACC_W-1:0]           result_d;

    // The element select relies on N_ELEM = 16, so idx concatenated with
    // zero bits forms the bit offset directly.
    assign w_sel = w_snap_q[{idx_q, 1'b0} +: 2];
    assign d_sel = d_snap_q[{idx_q, 3'b000} +: 8];

    // Both operands are widened to ACC_W before the multiply. The product
    // (-510..255) and the full-scale sum (-8160..4080) both fit, so
    // truncating to ACC_W bits is exact.
    assign w_ext = {{(ACC_W-2){w_sel[1]}}, w_sel};
    assign d_ext = {{(ACC_W-8){1'b0}}, d_sel};
    assign term  = w_ext * d_ext;
    assign acc_d = acc_q + term;

`ifdef DOT_RELU_EN
    assign result_d = acc_d[ACC_W-1] ? '0 : acc_d;
`else
    assign result_d = acc_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            acc_q    <= '0;
            w_snap_q <= '0;
            d_snap_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // When start and abort arrive together, abort wins.
                    if (start && !abort) begin
                        w_snap_q <= weights;
                        d_snap_q <= data;
                        acc_q    <= '0;
                        idx_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    // Abort beats the final-element update, which suppresses done.
                    if (abort) begin
                        busy_q  <= 1'b0;
                        idx_q   <= '0;
                        state_q <= IDLE;
                    end else if (idx_q == IDX_LAST) begin
                        acc_q    <= acc_d;
                        result_q <= result_d;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        idx_q    <= '0;
                        state_q  <= IDLE;
                    end else begin
                        acc_q <= acc_d;
                        idx_q <= idx_q + 4'd1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_dot_product_unit.sv
module tb_dot_product_unit;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         abort;
    logic [31:0]  weights;
    logic [127:0] data;
    logic         busy;
    logic         done;
    logic [13:0]  result;

    int n_checks;
    int n_pass;
    bit overlap_seen;

    dot_product_unit #(.N_ELEM(16), .ACC_W(14)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .weights (weights),
        .data    (data),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (busy && done) overlap_seen = 1'b1;

    typedef struct {
        string        nm;
        logic [31:0]  w;
        logic [127:0] d;
        logic [13:0]  exp_raw;
        logic [13:0]  exp_relu;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%04h expected 0x%04h", nm, act, exp);
    endtask

    function automatic logic [13:0] pick(input logic [13:0] raw, input logic [13:0] relu);
`ifdef DOT_RELU_EN
        return relu;
`else
        return raw;
`endif
    endfunction

    // Called right after the start edge; waits for done with a bounded budget.
    task automatic wait_done(input string nm, input logic [13:0] exp);
        int cyc;
        bit seen;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            tick();
            cyc++;
            if (done) seen = 1'b1;
        end
        chk({nm, "_latency"}, 16'(cyc), 16'd16);
        chk({nm, "_result"}, {2'b00, result}, {2'b00, exp});
        chk({nm, "_busy_at_done"}, {15'd0, busy}, 16'd0);
        tick();
        chk({nm, "_done_fall"}, {15'd0, done}, 16'd0);
    endtask

    task automatic run_vec(input string nm, input logic [31:0] w, input logic [127:0] d,
                           input logic [13:0] exp);
        weights = w;
        data    = d;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        chk({nm, "_busy_start"}, {15'd0, busy}, 16'd1);
        wait_done(nm, exp);
    endtask

    initial begin
        logic [31:0]  w_alt;
        logic [127:0] d_ramp;
        logic [127:0] d_one80;
        logic [31:0]  w_first;
        int           dn;

        n_checks     = 0;
        n_pass       = 0;
        overlap_seen = 1'b0;

        for (int i = 0; i < 16; i++) begin
            w_alt[2*i +: 2]  = (i % 2 == 0) ? 2'b01 : 2'b11;
            d_ramp[8*i +: 8] = 8'(i);
        end
        d_one80 = {16{8'h80}};
        w_first = 32'h0000_0001;

        vecs[0] = '{"ones",      {16{2'b01}}, {16{8'h01}}, 14'h0010, 14'h0010};
        vecs[1] = '{"neg_full",  {16{2'b10}}, {16{8'hFF}}, 14'h2020, 14'h0000};
        vecs[2] = '{"alt_ramp",  w_alt,       d_ramp,      14'h3FF8, 14'h0000};
        vecs[3] = '{"pos_full",  {16{2'b01}}, {16{8'hFF}}, 14'h0FF0, 14'h0FF0};
        vecs[4] = '{"first_only", w_first,    d_one80,     14'h0080, 14'h0080};
        vecs[5] = '{"neg2_ramp", {16{2'b10}}, d_ramp,      14'h3F10, 14'h0000};

        rst_n   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        weights = '0;
        data    = '0;
        #12;
        chk("reset_busy",   {15'd0, busy}, 16'd0);
        chk("reset_done",   {15'd0, done}, 16'd0);
        chk("reset_result", {2'b00, result}, 16'd0);
        #5 rst_n = 1'b1;
        tick();

        for (int v = 0; v < 6; v++)
            run_vec(vecs[v].nm, vecs[v].w, vecs[v].d, pick(vecs[v].exp_raw, vecs[v].exp_relu));

        // Restarts during RUN are ignored; a data change after the snapshot is invisible.
        weights = {16{2'b01}};
        data    = {16{8'h01}};
        start   = 1'b1;
        tick();
        dn = 0;
        for (int k = 1; k <= 16; k++) begin
            start = (k == 5 || k == 16);
            if (k == 3) data = {16{8'hFF}};
            tick();
            if (done) dn++;
            chk($sformatf("seq_done_e%0d", k), {15'd0, done}, (k == 16) ? 16'd1 : 16'd0);
            chk($sformatf("seq_busy_e%0d", k), {15'd0, busy}, (k < 16) ? 16'd1 : 16'd0);
        end
        chk("seq_result", {2'b00, result}, 16'h0010);
        // Start at E17 is accepted and uses the data now present (0xFF).
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("seq_e17_busy", {15'd0, busy}, 16'd1);
        chk("seq_e17_done", {15'd0, done}, 16'd0);
        if (done) dn++;
        chk("seq_done_count", 16'(dn), 16'd1);
        wait_done("seq_b2b", 14'h0FF0);

        // Abort in the middle of a run.
        weights = {16{2'b10}};
        data    = {16{8'hFF}};
        start   = 1'b1;
        tick();
        start   = 1'b0;
        for (int k = 1; k < 8; k++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort8_busy", {15'd0, busy}, 16'd0);
        dn = 0;
        for (int k = 0; k < 20; k++) begin
            if (done) dn++;
            tick();
        end
        chk("abort8_no_done", 16'(dn), 16'd0);
        chk("abort8_result", {2'b00, result}, 16'h0FF0);

        // Abort on the final element suppresses the result update.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 16; k++) tick();
        chk("abort15_busy_pre", {15'd0, busy}, 16'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort15_done", {15'd0, done}, 16'd0);
        chk("abort15_busy", {15'd0, busy}, 16'd0);
        chk("abort15_result", {2'b00, result}, 16'h0FF0);

        // Start together with abort in IDLE: nothing starts.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", {15'd0, busy}, 16'd0);
        dn = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done) dn++;
        end
        chk("start_abort_no_done", 16'(dn), 16'd0);

        // Asynchronous reset in the middle of a run.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_busy",   {15'd0, busy}, 16'd0);
        chk("rst_mid_done",   {15'd0, done}, 16'd0);
        chk("rst_mid_result", {2'b00, result}, 16'd0);
        #3 rst_n = 1'b1;
        tick();
        chk("rst_post_busy", {15'd0, busy}, 16'd0);
        run_vec("post_rst", {16{2'b01}}, {16{8'h01}}, 14'h0010);

        chk("busy_done_overlap", {15'd0, overlap_seen}, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
